wshb_master_seq: RTL

- Command-driven Wishbone classic master sequencer.
- Accepts one operation at a time on a valid/ready command port: WRITE, READ, IDLE, CFG_DELAY or CFG_TIMEOUT.
- Runs the matching single Wishbone cycle, timed wait or configuration update, and returns exactly one response per command.
- Sits between the bench/IPbus-side transaction source and any 64-bit Wishbone slave.
- Enforces a configurable inter-transaction gap and an ack timeout.

---
 rtl/wshb_seq_pkg.sv | 30 +++
 rtl/wshb_cycle_counter.sv | 37 +++
 rtl/wshb_master_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wshb_seq_pkg.sv
// Shared types for the Wishbone master sequencer: command opcodes, FSM states
// and the response record.
package wshb_seq_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [2:0] {
        OP_WRITE       = 3'd0,
        OP_READ        = 3'd1,
        OP_IDLE        = 3'd2,
        OP_CFG_DELAY   = 3'd3,
        OP_CFG_TIMEOUT = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BUS  = 3'd1,
        S_WAIT = 3'd2,
        S_RESP = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  err;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/wshb_cycle_counter.sv
// Saturating up-counter with clear/enable; tc_o flags the cycle whose increment
// reaches target_i, so a state left on tc_o lasts exactly target_i cycles.
module wshb_cycle_counter #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [TMO_W-1:0] target_i,
    output logic             tc_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;

    // A target of 0 can never match because the increment is at least 1.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    assign tc_o    = en_i && (cnt_inc == target_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wshb_master_seq.sv
// Wishbone classic master sequencer: one command in, one bus cycle, timed wait or
// config update performed, one response out, with an enforced inter-command gap.
//
// state  | meaning
// S_IDLE | cmd_ready high, waiting for a command
// S_BUS  | cyc/stb asserted, waiting for ack/err or timeout
// S_WAIT | IDLE command counting down its wait
// S_RESP | response presented until rsp_ready
// S_GAP  | enforced quiet period of delay_cfg cycles
module wshb_master_seq
    import wshb_seq_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SEL_W       = DATA_W / 8,
    parameter int TMO_W       = 16,
    parameter int DEF_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_adr,
    output logic [SEL_W-1:0]  wb_sel,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack,
    input  logic              wb_err,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [TMO_W-1:0]  delay_q, delay_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    rsp_t              rsp_q, rsp_d;

    logic              cnt_clr, cnt_en, cnt_tc;
    logic [TMO_W-1:0]  cnt_tgt;
    logic [DATA_W-1:0] rd_mask;
    logic              in_bus;

    always_comb begin
        rd_mask = '0;
        for (int k = 0; k < SEL_W; k++) begin
            rd_mask[8*k +: 8] = {8{sel_q[k]}};
        end
    end

    // Timeout, idle wait and gap are never active together, so one counter serves all.
    wshb_cycle_counter #(.TMO_W(TMO_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .target_i (cnt_tgt),
        .tc_o     (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        delay_d = delay_q;
        tmo_d   = tmo_q;
        rsp_d   = rsp_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        cnt_tgt = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    adr_d = cmd_addr;
                    sel_d = cmd_sel;
                    dat_d = cmd_data;
                    rsp_d = '0;
                    case (cmd_op)
                        OP_WRITE, OP_READ: state_d = S_BUS;
                        OP_IDLE: state_d = (cmd_data[TMO_W-1:0] == '0) ? S_RESP : S_WAIT;
                        OP_CFG_DELAY: begin
                            delay_d = cmd_data[TMO_W-1:0];
                            state_d = S_RESP;
                        end
                        OP_CFG_TIMEOUT: begin
                            tmo_d   = cmd_data[TMO_W-1:0];
                            state_d = S_RESP;
                        end
                        default: begin
                            rsp_d.err = 1'b1;
                            state_d   = S_RESP;
                        end
                    endcase
                end
            end
            S_BUS: begin
                cnt_en  = 1'b1;
                cnt_tgt = tmo_q;
                // err beats ack, and either beats a timeout landing on the same cycle
                if (wb_err) begin
                    rsp_d.err = 1'b1;
                    state_d   = S_RESP;
                end else if (wb_ack) begin
                    if (op_q == OP_READ) begin
                        rsp_d.data = wb_dat_i & rd_mask;
                    end
                    state_d = S_RESP;
                end else if (cnt_tc) begin
                    rsp_d.timeout = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_en  = 1'b1;
                cnt_tgt = dat_q[TMO_W-1:0];
                if (cnt_tc) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_clr = 1'b1;
                if (rsp_ready) begin
                    state_d = (delay_q != '0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                cnt_en  = 1'b1;
                cnt_tgt = delay_q;
                if (cnt_tc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            delay_q <= '0;
            tmo_q   <= TMO_W'(DEF_TIMEOUT);
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            delay_q <= delay_d;
            tmo_q   <= tmo_d;
            rsp_q   <= rsp_d;
        end
    end

    assign in_bus      = (state_q == S_BUS);
    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = rsp_q.data;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    assign wb_cyc   = in_bus;
    assign wb_stb   = in_bus;
    assign wb_we    = in_bus && (op_q == OP_WRITE);
    assign wb_adr   = in_bus ? adr_q : '0;
    assign wb_sel   = in_bus ? sel_q : '0;
    assign wb_dat_o = in_bus ? dat_q : '0;

endmodule
